// File: rtl/atm_account_arbiter_pkg.sv
// atm_pkg: opcodes, response status codes and FSM states shared by the ATM account arbiter.
package atm_pkg;
  typedef enum logic [1:0] {
    OP_QUERY    = 2'b00,
    OP_WITHDRAW = 2'b01,
    OP_DEPOSIT  = 2'b10,
    OP_ILLEGAL  = 2'b11
  } op_t;
  typedef enum logic [1:0] {
    ST_OK        = 2'b00,
    ST_INSUFF    = 2'b01,
    ST_OVF_LIMIT = 2'b10,
    ST_BAD       = 2'b11
  } status_t;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
endpackage

// File: rtl/atm_account_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first request at or above i_ptr, with wrap.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);
  logic [IW-1:0] w_j;
  always_comb begin
    o_idx = '0;
    w_j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IW'((int'(i_ptr) + k) % N);
      o_idx = i_req[w_j] ? w_j : o_idx;
    end
    o_grant = (|i_req) ? (N'(1) << o_idx) : '0;
  end
endmodule

// File: rtl/atm_account_arbiter.sv
// atm_account_arbiter: round-robin serialisation of terminal read-modify-write transactions on an
// owned account register file. Define ATM_DAILY_LIMIT_EN to add per-account daily withdrawal caps.
module atm_account_arbiter
  import atm_pkg::*;
#(
  parameter int NUM_TERM  = 4,
  parameter int NUM_ACCT  = 4,
  parameter int ACCT_W    = 2,
  parameter int BAL_W     = 21,
  parameter int INIT_BAL  = 10000,
  parameter int DAY_LIMIT = 5000,
  localparam int TW = (NUM_TERM > 1) ? $clog2(NUM_TERM) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_TERM-1:0]        req_valid,
  input  logic [2*NUM_TERM-1:0]      req_op,
  input  logic [ACCT_W*NUM_TERM-1:0] req_acct,
  input  logic [BAL_W*NUM_TERM-1:0]  req_amount,
  output logic [NUM_TERM-1:0]        req_ready,
  output logic                       rsp_valid,
  output logic [TW-1:0]              rsp_term,
  output logic [1:0]                 rsp_status,
  output logic [BAL_W-1:0]           rsp_balance,
  output logic                       busy
`ifdef ATM_DAILY_LIMIT_EN
  ,
  input  logic                       day_clear
`endif
);
  state_t            r_state;
  logic [TW-1:0]     r_ptr, r_term;
  op_t               r_op;
  logic [ACCT_W-1:0] r_acct;
  logic [BAL_W-1:0]  r_amt;
  logic [BAL_W-1:0]  r_bal [NUM_ACCT];
  logic [NUM_TERM-1:0] w_grant;
  logic [TW-1:0]     w_idx;
  logic              w_acct_ok, w_we, w_over;
  logic [BAL_W-1:0]  w_bal, w_new;
  logic [BAL_W:0]    w_sum;
  status_t           w_stat;

  rr_arbiter #(.N(NUM_TERM), .IW(TW)) u_arb (
    .i_req  (req_valid),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_idx  (w_idx)
  );

  assign req_ready = (r_state == S_IDLE) ? w_grant : '0;
  assign busy      = r_state != S_IDLE;
  assign w_acct_ok = int'(r_acct) < NUM_ACCT;
  assign w_bal     = w_acct_ok ? r_bal[r_acct] : '0;
  assign w_sum     = {1'b0, w_bal} + {1'b0, r_amt};

`ifdef ATM_DAILY_LIMIT_EN
  logic [BAL_W-1:0] r_acc [NUM_ACCT];
  assign w_over = ({1'b0, r_acc[r_acct]} + {1'b0, r_amt}) > (BAL_W + 1)'(DAY_LIMIT);
  always_ff @(posedge clk or posedge reset)
    if (reset || day_clear)
      for (int a = 0; a < NUM_ACCT; a++) r_acc[a] <= '0;
    else if (r_state == S_EXEC && w_we && r_op == OP_WITHDRAW)
      r_acc[r_acct] <= r_acc[r_acct] + r_amt;
`else
  assign w_over = 1'b0;
`endif

  // Insufficient funds outranks the daily limit; no write unless the op completes OK.
  always_comb begin
    w_new = w_bal;
    w_stat = ST_OK;
    if (!w_acct_ok || r_op == OP_ILLEGAL)
      w_stat = ST_BAD;
    else if (r_op == OP_WITHDRAW) begin
      w_stat = (r_amt > w_bal) ? ST_INSUFF : w_over ? ST_OVF_LIMIT : ST_OK;
      w_new = w_bal - r_amt;
    end else if (r_op == OP_DEPOSIT) begin
      w_stat = w_sum[BAL_W] ? ST_OVF_LIMIT : ST_OK;
      w_new = w_sum[BAL_W-1:0];
    end
  end
  assign w_we = (w_stat == ST_OK) && (r_op != OP_QUERY);

  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int a = 0; a < NUM_ACCT; a++) r_bal[a] <= BAL_W'(INIT_BAL);
    else if (r_state == S_EXEC && w_we)
      r_bal[r_acct] <= w_new;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_term      <= '0;
      r_op        <= OP_QUERY;
      r_acct      <= '0;
      r_amt       <= '0;
      rsp_valid   <= 1'b0;
      rsp_term    <= '0;
      rsp_status  <= '0;
      rsp_balance <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (|req_valid) begin
          r_term  <= w_idx;
          r_op    <= op_t'(req_op[2*w_idx +: 2]);
          r_acct  <= req_acct[ACCT_W*w_idx +: ACCT_W];
          r_amt   <= req_amount[BAL_W*w_idx +: BAL_W];
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          rsp_valid   <= 1'b1;
          rsp_term    <= r_term;
          rsp_status  <= w_stat;
          rsp_balance <= w_we ? w_new : w_bal;
          r_state     <= S_RESP;
        end
        default: begin
          r_ptr   <= (r_term == TW'(NUM_TERM - 1)) ? '0 : r_term + 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_atm_account_arbiter.sv
// tb_atm_account_arbiter: directed scenarios plus random traffic checked every cycle against a
// transaction-level model of the account store and round-robin order.
module tb_atm_account_arbiter;
  localparam int NT = 4;
  localparam int NA = 4;
  localparam int BW = 21;
  localparam int MAXB = (1 << BW) - 1;

  logic clk = 0, reset = 1;
  logic [NT-1:0] req_valid, req_ready;
  logic [2*NT-1:0] req_op;
  logic [2*NT-1:0] req_acct;
  logic [BW*NT-1:0] req_amount;
  logic rsp_valid, busy;
  logic [1:0] rsp_term, rsp_status;
  logic [BW-1:0] rsp_balance;
  logic day_clear;

  atm_account_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_acct(req_acct),
    .req_amount(req_amount), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_term(rsp_term),
    .rsp_status(rsp_status), .rsp_balance(rsp_balance), .busy(busy)
`ifdef ATM_DAILY_LIMIT_EN
    , .day_clear(day_clear)
`endif
  );

  always #5 clk = ~clk;

  logic [NT-1:0] t_v;
  logic [1:0] t_op [NT];
  logic [1:0] t_acct [NT];
  logic [BW-1:0] t_amt [NT];
  logic t_clr;
  int m_bal [NA];
  int m_acc [NA];
  int m_ptr, m_left, e_term, e_stat, e_bal;
  int l_term, l_stat, l_bal;
  int served [$];
  int n_cmp = 0, n_err = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply();
    req_valid = t_v;
    day_clear = t_clr;
    for (int t = 0; t < NT; t++) begin
      req_op[2*t +: 2] = t_op[t];
      req_acct[2*t +: 2] = t_acct[t];
      req_amount[BW*t +: BW] = t_amt[t];
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < NA; a++) begin m_bal[a] = 10000; m_acc[a] = 0; end
    m_ptr = 0; m_left = 0;
  endtask

  task automatic model_exec(int w);
    int op, a, amt, b;
    op = t_op[w]; a = t_acct[w]; amt = t_amt[w]; b = m_bal[a];
    e_term = w; e_bal = b;
    if (op == 3) e_stat = 3;
    else if (op == 0) e_stat = 0;
    else if (op == 1) begin
      if (amt > b) e_stat = 1;
`ifdef ATM_DAILY_LIMIT_EN
      else if (m_acc[a] + amt > 5000) e_stat = 2;
`endif
      else begin e_stat = 0; e_bal = b - amt; m_acc[a] += amt; end
    end else if (b + amt > MAXB) e_stat = 2;
    else begin e_stat = 0; e_bal = b + amt; end
    m_bal[a] = e_bal;
  endtask

  task automatic step();
    logic [NT-1:0] exp_ready;
    int w;
    @(negedge clk);
    apply();
    #1;
    exp_ready = '0;
    w = -1;
    if (t_clr) for (int a = 0; a < NA; a++) m_acc[a] = 0;
    if (m_left == 0) begin
      for (int k = NT - 1; k >= 0; k--) if (t_v[(m_ptr + k) % NT]) w = (m_ptr + k) % NT;
      if (w >= 0) exp_ready[w] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      check("busy_idle", busy, 0);
      check("rsp_valid_idle", rsp_valid, 0);
      if (w >= 0) begin model_exec(w); t_v[w] = 1'b0; m_left = 2; end
    end else begin
      check("req_ready_busy", req_ready, 0);
      check("busy", busy, 1);
      check("rsp_valid", rsp_valid, m_left == 1);
      if (m_left == 1) begin
        check("rsp_term", rsp_term, e_term);
        check("rsp_status", rsp_status, e_stat);
        check("rsp_balance", rsp_balance, e_bal);
        l_term = rsp_term; l_stat = rsp_status; l_bal = rsp_balance;
        served.push_back(int'(rsp_term));
        m_ptr = (e_term + 1) % NT;
      end
      m_left--;
    end
  endtask

  task automatic drain();
    int n = 0;
    do begin step(); n++; end while ((m_left != 0 || |t_v) && n < 100);
    if (n >= 100) begin n_cmp++; n_err++; $display("FAIL drain_timeout: got %0d cycles required < 100", n); end
  endtask

  task automatic req(int t, int op, int a, int amt);
    t_v[t] = 1'b1; t_op[t] = 2'(op); t_acct[t] = 2'(a); t_amt[t] = BW'(amt);
  endtask

  task automatic pin(string nm, int term, int stat, int bal);
    check({nm, "_term"}, l_term, term);
    check({nm, "_status"}, l_stat, stat);
    check({nm, "_balance"}, l_bal, bal);
  endtask

  task automatic do_reset();
    t_v = '0; t_clr = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    apply();
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_term", rsp_term, 0);
    check("rst_rsp_status", rsp_status, 0);
    check("rst_rsp_balance", rsp_balance, 0);
    model_reset();
    @(negedge clk);
    check("rst_rsp_valid_hold", rsp_valid, 0);
    reset = 1'b0;
  endtask

  initial begin
    t_v = '0; t_clr = 1'b0;
    for (int t = 0; t < NT; t++) begin t_op[t] = 0; t_acct[t] = 0; t_amt[t] = 0; end
    apply();
    model_reset();
    do_reset();
    // 1: query after reset
    req(0, 0, 2, 0); drain(); pin("q_init", 0, 0, 10000);
    // 2: withdraw then query
    req(1, 1, 1, 3000); drain(); pin("wd3000", 1, 0, 7000);
    req(1, 0, 1, 0); drain(); pin("q_after_wd", 1, 0, 7000);
    // 3: insufficient, then exact drain
    req(2, 1, 0, 10001); drain(); pin("wd_insuff", 2, 1, 10000);
    req(2, 1, 0, 10000); drain();
`ifdef ATM_DAILY_LIMIT_EN
    pin("wd_all", 2, 2, 10000);
`else
    pin("wd_all", 2, 0, 0);
`endif
    // 4: simultaneous requests from rr_ptr 0
    do_reset();
    for (int t = 0; t < NT; t++) req(t, 0, t, 0);
    served.delete();
    drain();
    check("order_count", served.size(), 4);
    for (int i = 0; i < 4 && i < served.size(); i++) check("order", served[i], i);
    req(0, 0, 0, 0); req(3, 0, 3, 0);
    served.delete();
    drain();
    check("pair_count", served.size(), 2);
    if (served.size() == 2) begin check("pair_first", served[0], 0); check("pair_second", served[1], 3); end
    // 5: overflow, bad request, reset during EXEC
    req(3, 2, 3, MAXB); drain(); pin("dep_ovf", 3, 2, 10000);
    req(2, 3, 3, 5); drain(); pin("bad_req", 2, 3, 10000);
    req(1, 1, 3, 500); step();
    do_reset();
    req(1, 0, 3, 0); drain(); pin("q_after_rst", 1, 0, 10000);
`ifdef ATM_DAILY_LIMIT_EN
    // 6: daily limit
    do_reset();
    req(0, 1, 0, 3000); drain(); pin("lim_wd1", 0, 0, 7000);
    req(0, 1, 0, 2500); drain(); pin("lim_wd2", 0, 2, 7000);
    t_clr = 1'b1; step(); t_clr = 1'b0;
    req(0, 1, 0, 2500); drain(); pin("lim_wd3", 0, 0, 4500);
`endif
    // random traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int t = 0; t < NT; t++) begin
        if (!t_v[t] && $urandom_range(2) == 0)
          req(t, $urandom_range(3), $urandom_range(3),
              ($urandom_range(9) == 0) ? MAXB - int'($urandom_range(15000)) : int'($urandom_range(4000)));
        else if (t_v[t] && $urandom_range(15) == 0)
          t_v[t] = 1'b0;
      end
`ifdef ATM_DAILY_LIMIT_EN
      t_clr = (m_left == 0 && t_v == '0 && $urandom_range(3) == 0);
`endif
      step();
    end
    t_clr = 1'b0;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
